// File: rtl/flash_cmd_seq.sv
// Command sequencer for a 16-bit AMD/CFI parallel NOR flash: single-word read,
// word program, sector erase and reset, with cycle-counted strobe timing and RY/BY# polling.
module flash_cmd_seq #(
  parameter int T_SETUP   = 2,
  parameter int T_WP      = 3,
  parameter int T_ACC     = 6,
  parameter int T_BUSY    = 5,
  parameter int TIMEOUT_W = 26
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [25:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [25:0] flash_a,
  output logic        flash_nce,
  output logic        flash_noe,
  output logic        flash_nwe,
  input  logic        flash_ready,
  output logic [15:0] bus_o,
  output logic        bus_oe,
  input  logic [15:0] bus_i
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
  localparam logic [7:0] WP_LAST    = 8'(T_WP - 1);
  localparam logic [7:0] ACC_LAST   = 8'(T_ACC - 1);
  localparam logic [7:0] BUSY_LAST  = 8'(T_BUSY - 1);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, R_END, BUSY_DLY, POLL, DONE
  } state_t;

  typedef struct packed {
    logic [25:0] a;
    logic [15:0] d;
  } step_t;

  // Address/data of bus write number idx within the unlock/command sequence of op.
  function automatic step_t step_word(input logic [1:0] op, input logic [2:0] idx,
                                      input logic [25:0] a, input logic [15:0] d);
    step_t w;
    w.a = a;
    w.d = d;
    case (op)
      OP_PROG: begin
        case (idx)
          3'd0:    begin w.a = 26'h555; w.d = 16'h00AA; end
          3'd1:    begin w.a = 26'h2AA; w.d = 16'h0055; end
          3'd2:    begin w.a = 26'h555; w.d = 16'h00A0; end
          default: ;
        endcase
      end
      OP_ERASE: begin
        case (idx)
          3'd0:    begin w.a = 26'h555; w.d = 16'h00AA; end
          3'd1:    begin w.a = 26'h2AA; w.d = 16'h0055; end
          3'd2:    begin w.a = 26'h555; w.d = 16'h0080; end
          3'd3:    begin w.a = 26'h555; w.d = 16'h00AA; end
          3'd4:    begin w.a = 26'h2AA; w.d = 16'h0055; end
          default: w.d = 16'h0030;
        endcase
      end
      default: w.d = 16'h00F0;
    endcase
    return w;
  endfunction

  function automatic logic is_last(input logic [1:0] op, input logic [2:0] idx);
    case (op)
      OP_PROG:  return idx == 3'd3;
      OP_ERASE: return idx == 3'd5;
      default:  return 1'b1;
    endcase
  endfunction

  state_t                 state_reg;
  logic [1:0]             op_reg;
  logic [25:0]            addr_reg;
  logic [15:0]            wdata_reg;
  logic [2:0]             step_reg;
  logic [7:0]             tmr_reg;
  logic [TIMEOUT_W-1:0]   tout_reg;
  logic [TIMEOUT_W-1:0]   tout_inc;
  logic                   rdy_meta;
  logic                   rdy_sync;
  step_t                  first_word;
  step_t                  next_word;
  logic                   cur_last;

  always_comb begin
    first_word = step_word(cmd_op, 3'd0, cmd_addr, cmd_wdata);
    next_word  = step_word(op_reg, step_reg + 3'd1, addr_reg, wdata_reg);
    cur_last   = is_last(op_reg, step_reg);
    tout_inc   = tout_reg + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      op_reg    <= OP_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
      step_reg  <= '0;
      tmr_reg   <= '0;
      tout_reg  <= '0;
      rdy_meta  <= 1'b0;
      rdy_sync  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      flash_a   <= '0;
      flash_nce <= 1'b1;
      flash_noe <= 1'b1;
      flash_nwe <= 1'b1;
      bus_o     <= '0;
      bus_oe    <= 1'b0;
    end else begin
      rdy_meta  <= flash_ready;
      rdy_sync  <= rdy_meta;
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_reg    <= cmd_op;
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            step_reg  <= '0;
            tmr_reg   <= '0;
            flash_nce <= 1'b0;
            if (cmd_op == OP_READ) begin
              flash_a   <= cmd_addr;
              flash_noe <= 1'b0;
              state_reg <= R_ACC;
            end else begin
              flash_a   <= first_word.a;
              bus_o     <= first_word.d;
              bus_oe    <= 1'b1;
              state_reg <= W_SETUP;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        W_SETUP: begin
          if (tmr_reg == SETUP_LAST) begin
            tmr_reg   <= '0;
            flash_nwe <= 1'b0;
            state_reg <= W_PULSE;
          end else begin
            tmr_reg <= tmr_reg + 8'd1;
          end
        end
        W_PULSE: begin
          if (tmr_reg == WP_LAST) begin
            tmr_reg   <= '0;
            flash_nwe <= 1'b1;
            flash_nce <= 1'b1;
            state_reg <= W_HOLD;
          end else begin
            tmr_reg <= tmr_reg + 8'd1;
          end
        end
        W_HOLD: begin
          // The bus stays driven across steps; it is released only when the sequence ends.
          if (cur_last) begin
            bus_oe <= 1'b0;
            if (op_reg == OP_RESET) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY_DLY;
            end
          end else begin
            step_reg  <= step_reg + 3'd1;
            flash_a   <= next_word.a;
            bus_o     <= next_word.d;
            flash_nce <= 1'b0;
            state_reg <= W_SETUP;
          end
        end
        R_ACC: begin
          if (tmr_reg == ACC_LAST) begin
            tmr_reg   <= '0;
            rsp_rdata <= bus_i;
            flash_nce <= 1'b1;
            flash_noe <= 1'b1;
            state_reg <= R_END;
          end else begin
            tmr_reg <= tmr_reg + 8'd1;
          end
        end
        R_END: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state_reg <= DONE;
        end
        BUSY_DLY: begin
          if (tmr_reg == BUSY_LAST) begin
            tmr_reg   <= '0;
            tout_reg  <= '0;
            state_reg <= POLL;
          end else begin
            tmr_reg <= tmr_reg + 8'd1;
          end
        end
        POLL: begin
          if (rdy_sync) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state_reg <= DONE;
          end else if (&tout_inc) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state_reg <= DONE;
          end else begin
            tout_reg <= tout_inc;
          end
        end
        DONE: begin
          rsp_err   <= 1'b0;
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Scoreboard bench for flash_cmd_seq: a stimulus-side model queues expected bus writes,
// reads and responses; a negedge monitor compares what the DUT actually does.
module tb_flash_cmd_seq;
  localparam int T_SETUP = 2;
  localparam int T_WP    = 3;
  localparam int T_ACC   = 6;
  localparam int T_BUSY  = 5;
  localparam int TW      = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [25:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [25:0] flash_a;
  logic        flash_nce, flash_noe, flash_nwe;
  logic        flash_ready = 1'b1;
  logic [15:0] bus_o;
  logic        bus_oe;
  logic [15:0] bus_i;

  always #5 clk = ~clk;

  flash_cmd_seq #(.T_SETUP(T_SETUP), .T_WP(T_WP), .T_ACC(T_ACC), .T_BUSY(T_BUSY),
                  .TIMEOUT_W(TW)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .flash_a(flash_a), .flash_nce(flash_nce), .flash_noe(flash_noe), .flash_nwe(flash_nwe),
    .flash_ready(flash_ready), .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  typedef struct {
    logic [25:0] a;
    logic [15:0] d;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [25:0] rd_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int ready_mode = 0;            // 0: ready high, 1: ready released later, 2: stuck busy
  logic [15:0] last_rd = '0;
  int nwe_falls = 0, last_rsp_cyc = -100;
  int setup_cnt = 0, low_cnt = 0, rd_cnt = 0;
  logic prev_nwe = 1'b1, prev_noe = 1'b1;

  // Flash array contents as seen by reads: a fixed function of the address.
  function automatic logic [15:0] data_of(input logic [25:0] a);
    if (a == 26'h0001234) return 16'hBEEF;
    return a[15:0] ^ {a[25:16], a[5:0]} ^ 16'h3C96;
  endfunction

  assign bus_i = (!flash_nce && !flash_noe) ? data_of(flash_a) : (16'hDEAD ^ cyc[15:0]);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_wr(input logic [25:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic push_expect(input logic [1:0] op, input logic [25:0] a, input logic [15:0] d);
    exp_t e;
    int nw, wcyc;
    nw = 0;
    wcyc = T_SETUP + T_WP + 1;
    e.lat = 0;
    case (op)
      2'd0: begin
        rd_q.push_back(a);
        last_rd = data_of(a);
        e.lat = 1 + T_ACC + 1;
      end
      2'd1: begin
        push_wr(26'h555, 16'h00AA); push_wr(26'h2AA, 16'h0055);
        push_wr(26'h555, 16'h00A0); push_wr(a, d);
        nw = 4;
      end
      2'd2: begin
        push_wr(26'h555, 16'h00AA); push_wr(26'h2AA, 16'h0055); push_wr(26'h555, 16'h0080);
        push_wr(26'h555, 16'h00AA); push_wr(26'h2AA, 16'h0055); push_wr(a, 16'h0030);
        nw = 6;
      end
      default: begin
        push_wr(a, 16'h00F0);
        e.lat = 1 + wcyc;
      end
    endcase
    if (nw != 0) begin
      if (ready_mode == 0)      e.lat = 1 + nw * wcyc + T_BUSY + 1;
      else if (ready_mode == 1) e.lat = -1;
      else                      e.lat = 1 + nw * wcyc + T_BUSY + ((1 << TW) - 1);
    end
    e.err   = (nw != 0) && (ready_mode == 2);
    e.rdata = last_rd;
    e.acc   = cyc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      prev_nwe = 1'b1; prev_noe = 1'b1;
      setup_cnt = 0; low_cnt = 0; rd_cnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) push_expect(cmd_op, cmd_addr, cmd_wdata);
      if (rsp_valid) begin
        exp_t e;
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
          else            check("rsp_after_ready", flash_ready, 1'b1);
          check("cmd_ready_in_done", cmd_ready, 1'b0);
        end
      end
      if (!flash_nwe && prev_nwe) begin
        wr_t w;
        nwe_falls++;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", flash_a, w.a);
          check("wr_data", bus_o, w.d);
          check("wr_setup_cycles", setup_cnt, T_SETUP);
          check("wr_oe_nce", {bus_oe, flash_nce}, 2'b10);
        end
      end
      if (!flash_nwe) low_cnt++;
      if (flash_nwe && !prev_nwe) begin
        check("wr_pulse_cycles", low_cnt, T_WP);
        check("wr_hold_nce", flash_nce, 1'b1);
        low_cnt = 0;
      end
      if (flash_nce) setup_cnt = 0;
      else if (flash_nwe && bus_oe) setup_cnt++;
      if (!flash_noe && prev_noe) begin
        if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else check("rd_addr", flash_a, rd_q.pop_front());
      end
      if (!flash_noe && !flash_nce) rd_cnt++;
      if (flash_noe && !prev_noe) begin
        check("rd_strobe_cycles", rd_cnt, T_ACC);
        rd_cnt = 0;
      end
      if (!flash_noe || !prev_noe) check("bus_contention", bus_oe, 1'b0);
      prev_nwe = flash_nwe;
      prev_noe = flash_noe;
    end
  end

  task automatic issue(input int op, input logic [25:0] a, input logic [15:0] d,
                       input bit hold, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    acc_cyc = -1;
    cmd_op = op[1:0]; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && cmd_ready;
    end
    if (!done) check("completion_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_err, flash_nce, flash_noe, flash_nwe, bus_oe},
          7'b0001110);
    check({tag, "_rdata"}, rsp_rdata, 16'h0);
    check({tag, "_addr_bus"}, {flash_a, bus_o}, 42'h0);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, base, op;
    bit hold, hit;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("ready_after_reset", cmd_ready, 1'b1);

    issue(0, 26'h0001234, 16'h0, 1'b0, a1);
    wait_done();

    ready_mode = 1; flash_ready = 1'b0;
    issue(1, 26'h0000100, 16'h5A5A, 1'b0, a1);
    repeat (40) begin @(posedge clk); #1; end
    flash_ready = 1'b1;
    wait_done();

    ready_mode = 2; flash_ready = 1'b0;
    issue(2, 26'h0020000, 16'h0, 1'b0, a1);
    wait_done();
    flash_ready = 1'b1; ready_mode = 0;
    repeat (3) begin @(posedge clk); #1; end

    issue(1, 26'h0000ABC, 16'h1357, 1'b1, a1);
    issue(0, 26'h0000ABC, 16'h0, 1'b0, a2);
    wait_done();

    base = nwe_falls;
    hit = 1'b0;
    issue(2, 26'h0030000, 16'h0, 1'b0, a1);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (nwe_falls == base + 4) && !flash_nwe;
    end
    check("reached_erase_step3_pulse", hit, 1'b1);
    nrst = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete(); wr_q.delete(); rd_q.delete();
    last_rd = '0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("abort_hold");
    nrst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    issue(0, 26'h0001234, 16'h0, 1'b0, a1);
    wait_done();

    issue(3, 26'h0000777, 16'h0, 1'b1, a1);
    issue(0, 26'h0000042, 16'h0, 1'b0, a2);
    check("b2b_accept_cycle", a2, last_rsp_cyc + 1);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      hold = (i < 59) && ($urandom_range(0, 1) == 1);
      issue(op, 26'($urandom), 16'($urandom), hold, a1);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_done();
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
